// File: rtl/data_send.sv
// Serial frame transmitter: start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
// Holding start high gives back-to-back frames with no idle gap.
module data_send #(
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter bit          PARITY_EN    = 1'b0,
  parameter bit          PARITY_ODD   = 1'b0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       start,
  output logic       txd
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam logic [15:0] BIT_RELOAD = 16'(CLKS_PER_BIT - 1);
  localparam logic [2:0]  LAST_STOP  = 3'(STOP_BITS - 1);

  state_t      state;
  logic [15:0] bit_cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shift_reg;
  logic        parity_bit;
  logic        bit_done;

  assign bit_done = (bit_cnt == 16'd0);

  // Parity is taken from the latched byte, so later data_in changes cannot leak into the frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      txd        <= 1'b1;
      bit_cnt    <= 16'd0;
      bit_idx    <= 3'd0;
      shift_reg  <= 8'h00;
      parity_bit <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state      <= START;
            shift_reg  <= data_in;
            parity_bit <= (^data_in) ^ PARITY_ODD;
            txd        <= 1'b0;
            bit_cnt    <= BIT_RELOAD;
            bit_idx    <= 3'd0;
          end else begin
            txd <= 1'b1;
          end
        end

        START: begin
          if (bit_done) begin
            state   <= DATA;
            txd     <= shift_reg[0];
            bit_cnt <= BIT_RELOAD;
            bit_idx <= 3'd0;
          end else begin
            bit_cnt <= bit_cnt - 16'd1;
          end
        end

        DATA: begin
          if (bit_done) begin
            bit_cnt <= BIT_RELOAD;
            if (bit_idx == 3'd7) begin
              bit_idx <= 3'd0;
              if (PARITY_EN) begin
                state <= PARITY;
                txd   <= parity_bit;
              end else begin
                state <= STOP;
                txd   <= 1'b1;
              end
            end else begin
              bit_idx   <= bit_idx + 3'd1;
              shift_reg <= {1'b0, shift_reg[7:1]};
              txd       <= shift_reg[1];
            end
          end else begin
            bit_cnt <= bit_cnt - 16'd1;
          end
        end

        PARITY: begin
          if (bit_done) begin
            state   <= STOP;
            txd     <= 1'b1;
            bit_cnt <= BIT_RELOAD;
            bit_idx <= 3'd0;
          end else begin
            bit_cnt <= bit_cnt - 16'd1;
          end
        end

        // The last cycle of the last stop bit is the only busy point where start is honoured.
        STOP: begin
          if (bit_done) begin
            if (bit_idx == LAST_STOP) begin
              bit_idx <= 3'd0;
              if (start) begin
                state      <= START;
                shift_reg  <= data_in;
                parity_bit <= (^data_in) ^ PARITY_ODD;
                txd        <= 1'b0;
                bit_cnt    <= BIT_RELOAD;
              end else begin
                state <= IDLE;
                txd   <= 1'b1;
              end
            end else begin
              bit_idx <= bit_idx + 3'd1;
              bit_cnt <= BIT_RELOAD;
              txd     <= 1'b1;
            end
          end else begin
            bit_cnt <= bit_cnt - 16'd1;
          end
        end

        default: begin
          state <= IDLE;
          txd   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_send.sv
// Drives four data_send variants in lockstep and compares every txd cycle against
// a frame-waveform model built from the byte, bit period, parity and stop settings.
module tb_data_send;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] data_in;
  logic       txd0, txd1, txd2, txd3;

  int checks = 0;
  int errors = 0;

  // Per-variant settings: bit period, parity enable, odd parity, stop bits.
  int cfg_c  [4] = '{4, 4, 3, 1};
  int cfg_pe [4] = '{0, 1, 1, 0};
  int cfg_po [4] = '{0, 0, 1, 0};
  int cfg_sb [4] = '{1, 1, 2, 2};

  // Model state: busy flag, cycle offset within frame, latched byte.
  bit       m_busy [4];
  int       m_pos  [4];
  bit [7:0] m_byte [4];
  bit       m_valid = 1'b0;

  data_send #(.CLKS_PER_BIT(4), .PARITY_EN(1'b0), .PARITY_ODD(1'b0), .STOP_BITS(1)) d0 (
    .clk(clk), .rst(rst), .data_in(data_in), .start(start), .txd(txd0));
  data_send #(.CLKS_PER_BIT(4), .PARITY_EN(1'b1), .PARITY_ODD(1'b0), .STOP_BITS(1)) d1 (
    .clk(clk), .rst(rst), .data_in(data_in), .start(start), .txd(txd1));
  data_send #(.CLKS_PER_BIT(3), .PARITY_EN(1'b1), .PARITY_ODD(1'b1), .STOP_BITS(2)) d2 (
    .clk(clk), .rst(rst), .data_in(data_in), .start(start), .txd(txd2));
  data_send #(.CLKS_PER_BIT(1), .PARITY_EN(1'b0), .PARITY_ODD(1'b0), .STOP_BITS(2)) d3 (
    .clk(clk), .rst(rst), .data_in(data_in), .start(start), .txd(txd3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int frame_len(int i);
    return (9 + cfg_pe[i] + cfg_sb[i]) * cfg_c[i];
  endfunction

  // Value of the frame at a given cycle offset: bit slot = offset / bit period.
  function automatic bit frame_bit(int i, bit [7:0] b, int pos);
    int k;
    k = pos / cfg_c[i];
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    if (cfg_pe[i] != 0 && k == 9) return (^b) ^ cfg_po[i][0];
    return 1'b1;
  endfunction

  function automatic bit expected_txd(int i);
    return m_busy[i] ? frame_bit(i, m_byte[i], m_pos[i]) : 1'b1;
  endfunction

  function automatic bit observed_txd(int i);
    case (i)
      0:       return txd0;
      1:       return txd1;
      2:       return txd2;
      default: return txd3;
    endcase
  endfunction

  task automatic checkOutput();
    logic obs, exp_v;
    if (m_valid) begin
      for (int i = 0; i < 4; i++) begin
        obs   = observed_txd(i);
        exp_v = expected_txd(i);
        checks++;
        assert (obs === exp_v) else begin
          errors++;
          $error("[TB] FAIL txd_d%0d at %0t: observed %b expected %b", i, $time, obs, exp_v);
        end
      end
    end
  endtask

  // One clock: check the current cycle, drive new inputs, then advance the model at the edge.
  task automatic applyStimulus(input logic r, input logic s, input logic [7:0] d);
    @(negedge clk);
    checkOutput();
    rst     = r;
    start   = s;
    data_in = d;
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      if (r) begin
        m_busy[i] = 1'b0;
      end else if (m_busy[i]) begin
        m_pos[i]++;
        if (m_pos[i] == frame_len(i)) m_busy[i] = 1'b0;
      end
      if (!r && !m_busy[i] && s) begin
        m_busy[i] = 1'b1;
        m_pos[i]  = 0;
        m_byte[i] = d;
      end
    end
    if (r) m_valid = 1'b1;
  endtask

  logic [11:0] cap;
  logic [7:0]  rnd_data;
  logic        rnd_start;
  logic        rnd_rst;

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    data_in = 8'h00;
    for (int i = 0; i < 4; i++) begin
      m_busy[i] = 1'b0;
      m_pos[i]  = 0;
      m_byte[i] = 8'h00;
    end

    $display("[TB] reset, with start high to show reset priority");
    applyStimulus(1'b1, 1'b1, 8'hFF);
    applyStimulus(1'b1, 1'b1, 8'hFF);
    applyStimulus(1'b1, 1'b0, 8'hFF);
    for (int k = 0; k < 4; k++) applyStimulus(1'b0, 1'b0, 8'h3C);

    $display("[TB] 0x01 single pulse, literal waveform on 1-cycle / 2-stop variant");
    applyStimulus(1'b0, 1'b1, 8'h01);
    #1 cap[0] = txd3;
    for (int k = 1; k < 12; k++) begin
      applyStimulus(1'b0, 1'b0, 8'h01);
      #1 cap[k] = txd3;
    end
    checks++;
    assert (cap === 12'hE02) else begin
      errors++;
      $error("[TB] FAIL literal_0x01: observed %h expected %h", cap, 12'hE02);
    end
    for (int k = 0; k < 45; k++) applyStimulus(1'b0, 1'b0, 8'h01);

    $display("[TB] 0xEE single pulse");
    applyStimulus(1'b0, 1'b1, 8'hEE);
    for (int k = 0; k < 50; k++) applyStimulus(1'b0, 1'b0, 8'hEE);

    $display("[TB] 0xA5 with data_in changed mid-frame and start re-pulsed while busy");
    applyStimulus(1'b0, 1'b1, 8'hA5);
    for (int k = 0; k < 6; k++) applyStimulus(1'b0, 1'b0, 8'hA5);
    applyStimulus(1'b0, 1'b1, 8'h00);
    for (int k = 0; k < 45; k++) applyStimulus(1'b0, 1'b0, 8'h00);

    $display("[TB] start held high, back-to-back 0xEE frames");
    for (int k = 0; k < 100; k++) applyStimulus(1'b0, 1'b1, 8'hEE);
    for (int k = 0; k < 50; k++) applyStimulus(1'b0, 1'b0, 8'hEE);

    $display("[TB] reset during data bit 3, then fresh start");
    applyStimulus(1'b0, 1'b1, 8'hA5);
    for (int k = 0; k < 17; k++) applyStimulus(1'b0, 1'b0, 8'hA5);
    applyStimulus(1'b1, 1'b0, 8'hA5);
    applyStimulus(1'b0, 1'b1, 8'h5A);
    for (int k = 0; k < 50; k++) applyStimulus(1'b0, 1'b0, 8'h5A);

    $display("[TB] randomized traffic");
    for (int k = 0; k < 1500; k++) begin
      rnd_data  = 8'($urandom);
      rnd_start = ($urandom_range(0, 3) == 0);
      rnd_rst   = ($urandom_range(0, 199) == 0);
      applyStimulus(rnd_rst, rnd_start, rnd_data);
    end
    for (int k = 0; k < 50; k++) applyStimulus(1'b0, 1'b0, 8'h00);
    @(negedge clk);
    checkOutput();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_send.md
DATA_SEND -- requirements
Module: data_send

Interface
REQ-001 CLKS_PER_BIT, default 4: clock cycles per serial bit, legal range 1..65535.
REQ-002 PARITY_EN, default 0: 1 inserts a parity bit after the data bits.
REQ-003 PARITY_ODD, default 0: parity sense when PARITY_EN=1; 0 = even, 1 = odd.
REQ-004 STOP_BITS, default 1: number of stop bits, legal values 1 or 2.
REQ-005 clk  input  1  single clock; all logic on its rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 data_in  input  8  byte to transmit; sampled only at frame start.
REQ-008 start  input  1  level request: send a frame while high.
REQ-009 txd  output  1  registered serial output; idle level 1.

Function
REQ-010 The block SHALL implement the FSM states IDLE, START, DATA, PARITY and STOP.
REQ-011 In IDLE, txd SHALL be 1; when start=1 at a rising edge, the FSM SHALL latch data_in into a shift register and enter START.
REQ-012 txd SHALL show the start bit (0) on the first cycle after the edge that sampled start=1; latency is exactly 1 cycle.
REQ-013 Every bit (start, data, parity, stop) SHALL hold txd for exactly CLKS_PER_BIT cycles, timed by a bit counter that reloads at each bit boundary.
REQ-014 DATA SHALL send 8 bits LSB first (bit 0 through bit 7).
REQ-015 PARITY, entered only when PARITY_EN=1, SHALL send the XOR of the 8 latched bits (even), or its inverse (odd).
REQ-016 STOP SHALL drive 1 for STOP_BITS bit periods.
REQ-017 Frame length SHALL be (1+8+PARITY_EN+STOP_BITS)*CLKS_PER_BIT cycles.
REQ-018 At the last cycle of the last stop bit: if start=1, the FSM SHALL relatch data_in and go directly to START, giving back-to-back frames with no idle gap; otherwise it SHALL return to IDLE.
REQ-019 Changes on data_in during a frame SHALL NOT affect the frame in progress.
REQ-020 start falling mid-frame SHALL NOT abort the frame; the current frame completes.
REQ-021 start pulses while busy, other than at the last stop cycle, SHALL be ignored, with no queuing.
REQ-022 txd SHALL be glitch-free: it is driven directly from a flip-flop.

Reset
REQ-023 While rst=1 at a rising edge, the next state SHALL be IDLE, txd 1, bit counter 0, bit index 0 and shift register 0x00.
REQ-024 rst asserted mid-frame SHALL abort the frame; txd is 1 from the next cycle on.
REQ-025 rst SHALL take priority over start in the same cycle.
REQ-026 After rst deasserts, a frame SHALL start no earlier than the first edge with rst=0 and start=1.

Verification
REQ-027 Defaults, data_in=0xEE, start pulsed high for 1 cycle -> txd per 4-cycle bit = 0 | 0,1,1,1,0,1,1,1 | 1; 40 cycles total, then stays 1.
REQ-028 Defaults, start held high, data_in=0xEE -> continuous 40-cycle frames with no gap; the start bit follows the stop bit immediately.
REQ-029 PARITY_EN=1, data_in=0xEE -> parity bit 0 (even, six ones); with PARITY_ODD=1 -> 1; frame 44 cycles.
REQ-030 Frame started with data_in=0xA5, data_in changed to 0x00 during DATA -> txd still shows the 0xA5 bits 1,0,1,0,0,1,0,1.
REQ-031 rst=1 asserted during data bit 3 -> txd=1 next cycle; FSM in IDLE; with start=1 after release, a fresh start bit follows 1 cycle later.
REQ-032 STOP_BITS=2, CLKS_PER_BIT=1, data_in=0x01, single start pulse -> txd = 0,1,0,0,0,0,0,0,0,1,1, then idle 1.
